// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, its source FIFO and its downstream sink.
// timeout_err exists only when FIFO_READER_TIMEOUT_EN is defined.
interface fifo_reader_if #(
    parameter int unsigned DATA_SIZE = 32
) ();
    logic [DATA_SIZE-1:0] fifo_data;
    logic                 fifo_empty;
    logic                 r_ack;
    logic                 start;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 busy;
    logic                 done;
`ifdef FIFO_READER_TIMEOUT_EN
    logic                 timeout_err;
`endif

    modport master (
        input  fifo_data, fifo_empty, start, out_ready,
        output r_ack, out_data, out_valid, busy, done
`ifdef FIFO_READER_TIMEOUT_EN
        , output timeout_err
`endif
    );

    modport slave (
        output fifo_data, fifo_empty, start, out_ready,
        input  r_ack, out_data, out_valid, busy, done
`ifdef FIFO_READER_TIMEOUT_EN
        , input timeout_err
`endif
    );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pops BURST_LEN words from a fall-through FIFO into a one-deep valid/ready stage.
// Define FIFO_READER_TIMEOUT_EN to add an empty-FIFO watchdog that aborts the burst.
module fifo_reader #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input logic           clk,
    input logic           nRST,
    fifo_reader_if.master bus
);
    localparam int unsigned RemW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [RemW-1:0]      remaining_q, remaining_d;
    logic [DATA_SIZE-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q, done_d;
    logic                 r_ack;

    // Pop only when the output stage is empty or is being emptied this cycle.
    assign r_ack = (state_q == RUN) && !bus.fifo_empty && (remaining_q != '0) &&
                   (!out_valid_q || bus.out_ready);

`ifdef FIFO_READER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_err_q, tmo_err_d;
    logic            tmo_hit;

    assign tmo_hit = (state_q == RUN) && bus.fifo_empty && (tmo_cnt_q == TmoW'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = 1'b0;
        if (state_q != RUN || r_ack || tmo_hit) begin
            tmo_cnt_d = '0;
        end else if (bus.fifo_empty) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        if (tmo_hit) begin
            tmo_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign bus.timeout_err = tmo_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        if (r_ack) begin
            out_data_d  = bus.fifo_data;
            out_valid_d = 1'b1;
            remaining_d = remaining_q - 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = RemW'(BURST_LEN);
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (r_ack && remaining_q == RemW'(1)) begin
                    state_d = DRAIN;
                end
`ifdef FIFO_READER_TIMEOUT_EN
                if (tmo_hit) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    remaining_d = '0;
                end
`endif
            end
            DRAIN: begin
                // Last word leaves (or already left) the output stage.
                if (!out_valid_q || bus.out_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.r_ack     = r_ack;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_fifo_reader.sv
// Randomized scoreboard bench for fifo_reader: each burst is expected to deliver the next
// BURST_LEN words of the FIFO stream, in order, followed by a done pulse one cycle later.
module tb_fifo_reader;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 16;
    localparam int unsigned TO = 8;
`ifdef FIFO_READER_TIMEOUT_EN
    localparam int unsigned FeedMin = 100;
`else
    localparam int unsigned FeedMin = 30;
`endif

    logic clk  = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_SIZE(DW)) bus ();

    fifo_reader #(
        .DATA_SIZE(DW),
        .BURST_LEN(BL),
        .TIMEOUT  (TO)
    ) dut (
        .clk (clk),
        .nRST(nRST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];    // words currently in the source FIFO
    logic [DW-1:0] stream_q[$];  // FIFO words not yet owed to any burst
    logic [DW-1:0] exp_q[$];     // words owed downstream, in order
    int claims = 0;              // words owed to a burst but not yet written to the FIFO

    int seq = 0;
    bit hi_rand = 1'b0;
    int feed_left = 0;
    int feed_prob = 100;
    int ready_mode = 0;
    bit chain_start = 1'b0;
    bit last_done = 1'b0;
    bit last_busy = 1'b0;
    int racks_seen = 0;
    int run_len = 0;
    int max_run = 0;
    int acc_seen = 0;

    function automatic void chk(string name, longint unsigned act, longint unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [DW-1:0] next_word();
        logic [DW-1:0] w;
        w = DW'(seq);
        if (hi_rand) w[DW-1:16] = 16'($urandom);
        seq++;
        return w;
    endfunction

    function automatic void push_word(logic [DW-1:0] w);
        fifo_q.push_back(w);
        if (claims > 0) begin
            exp_q.push_back(w);
            claims--;
        end else begin
            stream_q.push_back(w);
        end
    endfunction

    function automatic void claim_burst();
        int n = BL;
        while (n > 0 && stream_q.size() > 0) begin
            exp_q.push_back(stream_q.pop_front());
            n--;
        end
        claims += n;
    endfunction

    function automatic void drive_fifo();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
    endfunction

    function automatic void preload(int n);
        for (int i = 0; i < n; i++) push_word(next_word());
        drive_fifo();
    endfunction

    // One clock: sample at negedge, update the FIFO and drive inputs 1 ns after posedge.
    task automatic step();
        logic ra;
        @(negedge clk);
        ra        = bus.r_ack;
        last_done = bus.done;
        last_busy = bus.busy;
        if (bus.out_valid && bus.out_ready) acc_seen++;
        if (chain_start && bus.done) begin
            bus.start   = 1'b1;
            claim_burst();
            chain_start = 1'b0;
            feed_left  += int'(BL + $urandom_range(3));
        end
        @(posedge clk);
        #1;
        if (ra) begin
            racks_seen++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
        end else begin
            run_len = 0;
        end
        bus.start = 1'b0;
        if (feed_left > 0 && int'($urandom_range(99)) < feed_prob) begin
            push_word(next_word());
            feed_left--;
        end
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = !bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(1));
        endcase
        drive_fifo();
    endtask

    task automatic start_burst();
        bus.start = 1'b1;
        claim_burst();
        step();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_done && n < budget);
        chk({name, "_done_seen"}, longint'(last_done), 1);
    endtask

    // Monitor: scoreboard pop on every accepted word plus burst-level checks on done.
    int cyc = 0;
    int m_acc = 0;
    int m_rack = 0;
    int last_acc = -10;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        bit tmo;
        cyc++;
        if (!nRST) begin
            chk("rst_r_ack", bus.r_ack, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_busy", bus.busy, 0);
            m_acc      = 0;
            m_rack     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("word_expected", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) chk("out_data", bus.out_data, exp_q.pop_front());
                m_acc++;
                last_acc = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.r_ack) begin
                m_rack++;
                chk("r_ack_while_empty", bus.fifo_empty, 0);
            end
            if (bus.done) begin
                tmo = 1'b0;
`ifdef FIFO_READER_TIMEOUT_EN
                tmo = bus.timeout_err;
`endif
                if (!tmo) begin
                    chk("burst_words", longint'(m_acc), BL);
                    chk("burst_pops", longint'(m_rack), BL);
                    chk("done_latency", longint'(cyc - last_acc), 1);
                    chk("busy_at_done", bus.busy, 0);
                end
                m_acc  = 0;
                m_rack = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int racks_before;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        drive_fifo();

        // Reset values before any clock edge.
        #3;
        chk("por_r_ack", bus.r_ack, 0);
        chk("por_out_valid", bus.out_valid, 0);
        chk("por_out_data", bus.out_data, 0);
        chk("por_done", bus.done, 0);
        chk("por_busy", bus.busy, 0);
        repeat (3) @(posedge clk);
        #1;
        nRST = 1'b1;

        // Full burst of 0..15 with no backpressure.
        seq = 0; hi_rand = 1'b0; ready_mode = 0; bus.out_ready = 1'b1;
        preload(16);
        max_run = 0; run_len = 0;
        start_burst();
        wait_done(60, "full");
        chk("full_consecutive_r_ack", longint'(max_run), 16);
        chk("full_fifo_left", longint'(fifo_q.size()), 0);

        // Backpressure: out_ready toggles every cycle.
        hi_rand = 1'b1; ready_mode = 1;
        preload(16);
        start_burst();
        wait_done(120, "backpressure");

`ifndef FIFO_READER_TIMEOUT_EN
        // Starvation: FIFO runs dry after word 5 for 20 cycles, then refills.
        seq = 0; hi_rand = 1'b0; ready_mode = 0;
        preload(6);
        racks_before = racks_seen;
        start_burst();
        n = 0;
        while (fifo_q.size() != 0 && n < 30) begin
            step();
            n++;
        end
        chk("starve_drained", longint'(fifo_q.size()), 0);
        n = racks_seen;
        repeat (20) step();
        chk("starve_gap_r_ack", longint'(racks_seen - n), 0);
        chk("starve_busy", longint'(last_busy), 1);
        preload(10);
        wait_done(60, "starve");
        chk("starve_total_pops", longint'(racks_seen - racks_before), 16);
`endif

        // Over-supply: 30 words available, only one burst taken.
        hi_rand = 1'b1; ready_mode = 0;
        preload(30);
        start_burst();
        wait_done(60, "oversupply");
        chk("oversupply_fifo_left", longint'(fifo_q.size()), 14);

        // Back-to-back random bursts, each started in the done cycle of the previous one.
        feed_left = BL;
        feed_prob = 60;
        ready_mode = 2;
        start_burst();
        for (int i = 0; i < 5; i++) begin
            chain_start = 1'b1;
            feed_prob   = int'($urandom_range(100, FeedMin));
            ready_mode  = int'($urandom_range(2));
            wait_done(400, "chain");
            step();
            chk("chain_busy", longint'(last_busy), 1);
        end
        wait_done(400, "chain_last");

        // Reset in the middle of a burst after 7 words.
        feed_left = 0; ready_mode = 0; feed_prob = 100;
        fifo_q.delete(); stream_q.delete(); exp_q.delete(); claims = 0;
        preload(16);
        start_burst();
        acc_seen = 0;
        n = 0;
        while (acc_seen < 7 && n < 50) begin
            step();
            n++;
        end
        chk("midreset_words_before", longint'(acc_seen), 7);
        #2;
        nRST = 1'b0;
        #1;
        chk("midreset_r_ack", bus.r_ack, 0);
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_out_data", bus.out_data, 0);
        chk("midreset_done", bus.done, 0);
        chk("midreset_busy", bus.busy, 0);
        fifo_q.delete(); stream_q.delete(); exp_q.delete(); claims = 0;
        drive_fifo();
        repeat (3) step();
        nRST = 1'b1;
        preload(16);
        start_burst();
        wait_done(60, "post_reset");

`ifdef FIFO_READER_TIMEOUT_EN
        // Empty FIFO after start: watchdog aborts after TO empty RUN cycles.
        fifo_q.delete(); stream_q.delete(); exp_q.delete(); claims = 0;
        drive_fifo();
        start_burst();
        n = 0;
        do begin
            step();
            n++;
        end while (!last_done && n < 40);
        chk("timeout_latency", longint'(n), TO + 1);
        chk("timeout_busy", longint'(last_busy), 0);
        exp_q.delete(); claims = 0;
`endif

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
